imem_stream_loader: RTL and testbench

- Boot-time program loader for the single-cycle RISC-V core.
- Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes the words sequentially into the instruction memory write port.
- Holds the CPU in reset until the full program is written, replacing simulation-only memory preloading with a synthesizable path.

---
 rtl/imem_stream_loader_if.sv | 27 ++
 rtl/imem_stream_loader.sv | 146 ++++++++++++++
 tb/tb_imem_stream_loader.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/imem_stream_loader_if.sv
// Handshake and memory-write bundle between a boot stream source and the instruction loader.
interface imem_stream_loader_if #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
);
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, busy, done, err
  );

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, imem_we, imem_waddr, imem_wdata, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/imem_stream_loader.sv
// Boot-time loader: takes a length-prefixed byte stream, packs little-endian words
// into instruction memory and keeps the CPU in reset until the program is complete.
module imem_stream_loader #(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  imem_stream_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, LAST, DONE, ERR
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        lane_q, lane_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [23:0]       word_q, word_d;

  logic              rx_ready_q, rx_ready_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              hs;
  logic [15:0]       hdr_len;
  logic              hdr_bad;
  logic              last_word;

  assign hs        = bus.rx_valid && rx_ready_q;
  assign hdr_len   = {bus.rx_data, len_q[7:0]};
  assign hdr_bad   = (hdr_len == 16'd0) || (32'(hdr_len) > 32'(IMEM_DEPTH));
  assign last_word = (16'(idx_q) == (len_q - 16'd1));

  // Next-state, datapath and registered-output decode
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (bus.start) begin
          state_d = LEN0;
          idx_d   = '0;
          lane_d  = 2'd0;
        end
      end
      LEN0: begin
        if (hs) begin
          len_d[7:0] = bus.rx_data;
          state_d    = LEN1;
        end
      end
      LEN1: begin
        if (hs) begin
          len_d[15:8] = bus.rx_data;
          idx_d       = '0;
          lane_d      = 2'd0;
          state_d     = hdr_bad ? ERR : DATA;
        end
      end
      DATA: begin
        if (hs) begin
          if (lane_q == 2'd3) begin
            // Fourth byte completes the word; write goes out on the same edge
            we_d    = 1'b1;
            waddr_d = idx_q;
            wdata_d = {bus.rx_data, word_q};
            idx_d   = idx_q + ADDR_W'(1);
            lane_d  = 2'd0;
            if (last_word) state_d = LAST;
          end else begin
            case (lane_q)
              2'd0:    word_d[7:0]   = bus.rx_data;
              2'd1:    word_d[15:8]  = bus.rx_data;
              default: word_d[23:16] = bus.rx_data;
            endcase
            lane_d = lane_q + 2'd1;
          end
        end
      end
      LAST:    state_d = DONE;
      default: state_d = IDLE;
    endcase

    rx_ready_d = (state_d == LEN0) || (state_d == LEN1) || (state_d == DATA);
    busy_d     = rx_ready_d || (state_d == LAST);
    done_d     = (state_d == DONE);
    err_d      = (state_d == ERR);
    cpu_rst_d  = (state_d != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      lane_q     <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      lane_q     <= lane_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      rx_ready_q <= rx_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign bus.cpu_rst    = cpu_rst_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: directed streams, expected writes queued, monitor compares.
module tb_imem_stream_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk;
  logic rst;

  imem_stream_loader_if #(.IMEM_DEPTH(DEPTH)) bus ();

  imem_stream_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int  checks = 0;
  int  errors = 0;
  int  wr_count = 0;
  wr_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && bus.imem_we) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.imem_waddr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.imem_waddr !== e.addr || bus.imem_wdata !== e.data) begin
          errors++;
          $display("FAIL write: got addr %h data %h expected addr %h data %h",
                   bus.imem_waddr, bus.imem_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic expect_wr(input logic [AW-1:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Offer one byte and return #1 after the edge on which it was accepted
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rx_ready && n < 50);
    if (!bus.rx_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got rx_ready 0 expected 1 within 50 cycles");
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_stream(input logic [7:0] bytes[$], input bit gaps, input int start_at);
    foreach (bytes[i]) begin
      if (i == start_at) pulse_start();
      if (gaps && i != 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      if (gaps && i != 0) #1;
      send_byte(bytes[i]);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
    check({tag, "_waddr"}, 32'(bus.imem_waddr), 32'd0);
    check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
    check({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'd1);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_err"}, 32'(bus.err), 32'd0);
  endtask

  // Called #1 after the final byte edge: pulse cycle, then done one cycle later
  task automatic check_finish(input string tag);
    @(negedge clk);
    check({tag, "_last_we"}, 32'(bus.imem_we), 32'd1);
    check({tag, "_last_cpu_rst"}, 32'(bus.cpu_rst), 32'd1);
    check({tag, "_last_done"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'd0);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_we_off"}, 32'(bus.imem_we), 32'd0);
  endtask

  logic [7:0] two_word[$] = '{8'h02, 8'h00, 8'hB3, 8'h82, 8'h20, 8'h00, 8'h33, 8'h83, 8'h32, 8'h00};
  logic [7:0] one_word[$] = '{8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
  logic [7:0] alt_word[$] = '{8'h01, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] hdr_zero[$] = '{8'h00, 8'h00};
  logic [7:0] hdr_big[$]  = '{8'h01, 8'h01};
  logic [7:0] partial[$]  = '{8'h02, 8'h00, 8'hB3, 8'h82};

  initial begin
    int base;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    #3;
    check_reset_vals("por");
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back two-word load
    expect_wr(AW'(0), 32'h002082B3);
    expect_wr(AW'(1), 32'h00328333);
    pulse_start();
    check("len0_busy", 32'(bus.busy), 32'd1);
    send_stream(two_word, 1'b0, -1);
    check_finish("b2b");

    // Restart from DONE: CPU goes back into reset, reload from addr 0 with gaps and a stray start
    pulse_start();
    check("restart_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("restart_busy", 32'(bus.busy), 32'd1);
    base = wr_count;
    expect_wr(AW'(0), 32'h002082B3);
    expect_wr(AW'(1), 32'h00328333);
    send_stream(two_word, 1'b1, 5);
    check_finish("gap");
    check("gap_write_count", 32'(wr_count - base), 32'd2);

    // Zero-length header
    pulse_start();
    send_stream(hdr_zero, 1'b0, -1);
    @(negedge clk);
    check("zero_err", 32'(bus.err), 32'd1);
    check("zero_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("zero_cpu_rst", 32'(bus.cpu_rst), 32'd1);
    check("zero_busy", 32'(bus.busy), 32'd0);

    // Start clears err; oversize header
    pulse_start();
    check("clr_err", 32'(bus.err), 32'd0);
    check("clr_rx_ready", 32'(bus.rx_ready), 32'd1);
    send_stream(hdr_big, 1'b0, -1);
    @(negedge clk);
    check("big_err", 32'(bus.err), 32'd1);
    check("big_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("big_cpu_rst", 32'(bus.cpu_rst), 32'd1);

    // Recovery with a fresh header
    pulse_start();
    expect_wr(AW'(0), 32'h00100093);
    send_stream(alt_word, 1'b0, -1);
    check_finish("recover");

    // Asynchronous reset mid-word, two data bytes into word 0
    pulse_start();
    send_stream(partial, 1'b0, -1);
    #3;
    rst = 1'b1;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    rst = 1'b0;
    pulse_start();
    expect_wr(AW'(0), 32'h00000013);
    send_stream(one_word, 1'b0, -1);
    check_finish("after_rst");

    repeat (3) @(negedge clk);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
